// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID pipeline register with a 2-entry skid buffer, registered in_ready and synchronous flush.
//   clk, rst (async, active-high)  flush: squash held entries on redirect
//   in_valid/in_ready/in_pc/in_instr: fetch side   out_valid/out_ready/out_pc/out_instr: decode side
module if_id_skid_reg #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, main_instr_q, main_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
  logic accept, issue;
  assign accept = in_valid && in_ready;
  assign issue = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_pc_q <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      main_pc_q <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end
  // Data writes during flush are harmless: the entries are invalidated by the state.
  always_comb begin
    state_d = state_q;
    main_pc_d = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d = skid_pc_q;
    skid_instr_d = skid_instr_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = BUSY;
        main_pc_d = in_pc;
        main_instr_d = in_instr;
      end
      BUSY: if (accept && issue) begin
        main_pc_d = in_pc;
        main_instr_d = in_instr;
      end else if (accept) begin
        state_d = FULL;
        skid_pc_d = in_pc;
        skid_instr_d = in_instr;
      end else if (issue) begin
        state_d = EMPTY;
      end
      FULL: if (issue) begin
        state_d = BUSY;
        main_pc_d = skid_pc_q;
        main_instr_d = skid_instr_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  // Handshake outputs decode only the state flop, so out_ready never reaches in_ready.
  always_comb begin
    in_ready = state_q != FULL;
    out_valid = state_q != EMPTY;
    out_pc = main_pc_q;
    out_instr = (state_q != EMPTY) ? main_instr_q : NOP_INSTR;
  end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: scoreboard bench for if_id_skid_reg with directed and random traffic.
module tb_if_id_skid_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  int n_checks = 0, n_errors = 0;
  int occ = 0;
  ent_t sb[$];
  if_id_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a 2-deep FIFO whose readiness depends only on its occupancy before the edge.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl, input logic tog);
    logic r;
    logic a, i;
    in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    if (tog) begin
      r = in_ready;
      out_ready = ~ordy;
      #1;
      chk("in_ready_comb", {31'b0, in_ready}, {31'b0, r});
      out_ready = ordy;
    end
    @(posedge clk);
    a = iv && occ < 2;
    i = occ > 0 && ordy;
    if (rst || fl) begin
      occ = 0;
      sb.delete();
    end else begin
      occ = occ - int'(i) + int'(a);
      if (a) sb.push_back('{pc, ins});
    end
    #1;
  endtask
  // Monitor: sampled at negedge, when all inputs for the coming edge are stable.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, occ < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, occ > 0});
      if (!out_valid) chk("nop_instr", out_instr, NOP);
      else if (sb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_out: got pc %08h expected no entry", out_pc);
      end else begin
        chk("out_pc", out_pc, sb[0].pc);
        chk("out_instr", out_instr, sb[0].instr);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, NOP);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) cyc(1, 32'(4 * k), 32'h0050_0093 + 32'(k << 20), 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h100, 32'h0010_0113, 0, 0, 0);
    cyc(1, 32'h104, 32'h0020_0113, 0, 0, 0);
    cyc(1, 32'h108, 32'h0030_0113, 0, 0, 1);
    chk("bp_in_ready", {31'b0, in_ready}, 0);
    chk("bp_out_pc", out_pc, 32'h100);
    cyc(1, 32'h108, 32'h0030_0113, 0, 0, 0);
    cyc(1, 32'h108, 32'h0030_0113, 1, 0, 0);
    cyc(1, 32'h108, 32'h0030_0113, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h200, 32'h0040_0113, 0, 0, 0);
    cyc(1, 32'h204, 32'h0050_0113, 0, 0, 0);
    cyc(1, 32'h208, 32'h0060_0113, 0, 1, 0);
    chk("flush_out_valid", {31'b0, out_valid}, 0);
    chk("flush_in_ready", {31'b0, in_ready}, 1);
    chk("flush_out_instr", out_instr, NOP);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h300, 32'h0070_0113, 0, 0, 0);
    cyc(1, 32'h304, 32'h0080_0113, 1, 0, 0);
    chk("bypass_out_pc", out_pc, 32'h304);
    chk("bypass_in_ready", {31'b0, in_ready}, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h400, 32'h0090_0113, 0, 0, 0);
    cyc(1, 32'h404, 32'h00a0_0113, 0, 0, 0);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    rst = 1;
    occ = 0;
    sb.delete();
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_out_instr", out_instr, NOP);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
    for (int k = 0; k < 1000; k++)
      cyc(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * k), $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), 1'(k % 4 == 0));
    for (int k = 0; k < 10 && occ > 0; k++) cyc(0, 0, 0, 1, 0, 0);
    chk("drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
